mac_stream_acc: RTL and testbench

- Parametrised, pipelined streaming multiply-accumulate unit; next generation of the team's single-lane MAC.
- Consumes a stream of operand pairs with valid/ready handshake.
- A per-beat `in_last` tag delimits dot-product vectors. Each vector result is delivered through an output valid/ready register with beat count. The accumulator auto-clears between vectors.
- Per-beat signed/unsigned mode; sits between the operand fetch logic and the PE writeback path.

---
 rtl/mac_stream_acc.sv | 156 +++++++++++++++
 tb/tb_mac_stream_acc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_acc.sv
// Pipelined streaming multiply-accumulate: operand register, MULT_LAT product stages, accumulate/result stage.
// Define MAC_STREAM_SAT_EN to clamp sums to the signed ACC_W range and report per-vector overflow on out_ovf.
module mac_stream_acc #(
    parameter int W        = 32,
    parameter int GUARD    = 8,
    parameter int MULT_LAT = 2,
    parameter int CNT_W    = 16,
    localparam int ACC_W   = 2*W + GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_signed,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    // Extending both operands to 2W in the beat's mode makes the truncated 2W product exact.
    function automatic logic signed [ACC_W-1:0] ext_mult(input logic [W-1:0] a,
                                                         input logic [W-1:0] b,
                                                         input logic sgn);
        logic signed [2*W-1:0] pa;
        logic signed [2*W-1:0] pb;
        logic signed [2*W-1:0] p;
        if (sgn) begin
            pa = {{W{a[W-1]}}, a};
            pb = {{W{b[W-1]}}, b};
        end else begin
            pa = {{W{1'b0}}, a};
            pb = {{W{1'b0}}, b};
        end
        p = pa * pb;
        if (sgn)
            return {{GUARD{p[2*W-1]}}, p};
        else
            return {{GUARD{1'b0}}, p};
    endfunction

`ifdef MAC_STREAM_SAT_EN
    // Returns {clamped, value}; overflow shows as disagreement of the two top bits of the wide sum.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] x,
                                               input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W:0] s;
        s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W])
                return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            else
                return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction
`endif

    logic stall;
    logic adv;

    logic [W-1:0]            a_p0;
    logic [W-1:0]            b_p0;
    logic                    sgn_p0;
    logic                    vld_p  [0:MULT_LAT];
    logic                    last_p [0:MULT_LAT];
    logic signed [ACC_W-1:0] prod_p [1:MULT_LAT];

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] sum;
    logic                    acc_fire;
    logic                    acc_last;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;
    assign acc_fire = vld_p[MULT_LAT];
    assign acc_last = vld_p[MULT_LAT] && last_p[MULT_LAT];

`ifdef MAC_STREAM_SAT_EN
    logic sum_ovf;
    logic ovf_acc;

    always_comb begin
        {sum_ovf, sum} = sat_add(acc, prod_p[MULT_LAT]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_acc <= 1'b0;
            out_ovf <= 1'b0;
        end else if (adv && acc_fire) begin
            if (acc_last) begin
                out_ovf <= ovf_acc | sum_ovf;
                ovf_acc <= 1'b0;
            end else begin
                ovf_acc <= ovf_acc | sum_ovf;
            end
        end
    end
`else
    assign sum     = acc + prod_p[MULT_LAT];
    assign out_ovf = 1'b0;
`endif

    // Stage p0 -> p1..pMULT_LAT: operand capture and product pipeline (data only, no reset).
    always_ff @(posedge clk) begin
        if (adv) begin
            a_p0      <= in_a;
            b_p0      <= in_b;
            sgn_p0    <= in_signed;
            prod_p[1] <= ext_mult(a_p0, b_p0, sgn_p0);
            for (int i = 2; i <= MULT_LAT; i++)
                prod_p[i] <= prod_p[i-1];
        end
    end

    // Tags travel with the data; accumulate/result stage follows pMULT_LAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= MULT_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                last_p[i] <= 1'b0;
            end
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (adv) begin
            vld_p[0]  <= in_valid;
            last_p[0] <= in_valid && in_last;
            for (int i = 1; i <= MULT_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
            out_valid <= acc_last;
            if (acc_fire) begin
                if (acc_last) begin
                    out_data  <= sum;
                    out_count <= cnt + CNT_W'(1);
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_stream_acc.sv
// Scoreboard bench for mac_stream_acc (W=8, GUARD=4, MULT_LAT=2); honours MAC_STREAM_SAT_EN for overflow expectations.
module tb_mac_stream_acc;
    localparam int W     = 8;
    localparam int GUARD = 4;
    localparam int ML    = 2;
    localparam int CNT_W = 16;
    localparam int ACC_W = 2*W + GUARD;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_signed;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    mac_stream_acc #(.W(W), .GUARD(GUARD), .MULT_LAT(ML), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic expect_res(input logic [ACC_W-1:0] d, input logic [CNT_W-1:0] c, input logic o);
        sb.push_back('{data: d, cnt: c, ovf: o});
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic l);
        int t;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_last = l;
        #1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: got in_ready 0 required 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: a result handshake completes at the next rising edge when valid and ready are both high.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got %0h required none", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                    check("out_count", 32'(out_count), 32'(mon_e.cnt));
                    check("out_ovf", 32'(out_ovf), 32'(mon_e.ovf));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Signed vector 3*4 + -2*5 + 7*-1 = -5, plus latency.
        expect_res(20'hFFFFB, 16'd3, 1'b0);
        beat(8'd3, 8'd4, 1'b1, 1'b0);
        beat(8'hFE, 8'd5, 1'b1, 1'b0);
        beat(8'd7, 8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("lat_edge_k2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge_k3", 32'(out_valid), 32'd1);
        repeat (3) @(negedge clk);

        // Unsigned 255*255 then signed -1*-1, back to back.
        expect_res(20'h0FE01, 16'd1, 1'b0);
        expect_res(20'h00001, 16'd1, 1'b0);
        beat(8'hFF, 8'hFF, 1'b0, 1'b1);
        check("in_ready_b2b", 32'(in_ready), 32'd1);
        beat(8'hFF, 8'hFF, 1'b1, 1'b1);
        check("in_ready_b2b2", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);

        // Backpressure with two 2-beat vectors, then a beat held while stalled.
        out_ready = 1'b0;
        expect_res(20'd5, 16'd2, 1'b0);
        expect_res(20'd25, 16'd2, 1'b0);
        expect_res(20'd49, 16'd1, 1'b0);
        beat(8'd1, 8'd1, 1'b0, 1'b0);
        beat(8'd2, 8'd2, 1'b0, 1'b1);
        beat(8'd3, 8'd3, 1'b0, 1'b0);
        beat(8'd4, 8'd4, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_data", 32'(out_data), 32'd5);
        in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_signed = 1'b0; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Nine unsigned 255*255 beats: 585225 overflows the 20-bit signed range.
`ifdef MAC_STREAM_SAT_EN
        expect_res(20'h7FFFF, 16'd9, 1'b1);
`else
        expect_res(20'h8EE09, 16'd9, 1'b0);
`endif
        expect_res(20'd1, 16'd1, 1'b0);
        for (int i = 0; i < 9; i++)
            beat(8'hFF, 8'hFF, 1'b0, (i == 8));
        beat(8'd1, 8'd1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);

        // Reset mid-vector discards the partial sum and in-flight beats.
        beat(8'd10, 8'd10, 1'b0, 1'b0);
        beat(8'd10, 8'd10, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        check("midrst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_res(20'd6, 16'd1, 1'b0);
        beat(8'd2, 8'd3, 1'b0, 1'b1);

        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk); t++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
